// File: rtl/shift_exec_stage_if.sv
// Handshake and shifter bundle for the shift execute stage.
// slave is the stage side; master is the ID/shifter/MEM side.
interface shift_exec_stage_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [5:0]            in_funct;
    logic [4:0]            in_shamt;
    logic [DATA_WIDTH-1:0] in_rs_val;
    logic [DATA_WIDTH-1:0] in_rt_val;
    logic [4:0]            in_rd;

    logic [DATA_WIDTH-1:0] sh_A;
    logic [4:0]            sh_B;
    logic [1:0]            sh_Shiftop;
    logic [DATA_WIDTH-1:0] sh_Result;

    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_result;
    logic [4:0]            out_rd;
    logic                  out_illegal;
    logic [CNT_WIDTH-1:0]  op_count;

    modport slave (
        input  in_valid,
        output in_ready,
        input  in_funct,
        input  in_shamt,
        input  in_rs_val,
        input  in_rt_val,
        input  in_rd,
        output sh_A,
        output sh_B,
        output sh_Shiftop,
        input  sh_Result,
        output out_valid,
        input  out_ready,
        output out_result,
        output out_rd,
        output out_illegal,
        output op_count
    );

    modport master (
        output in_valid,
        input  in_ready,
        output in_funct,
        output in_shamt,
        output in_rs_val,
        output in_rt_val,
        output in_rd,
        input  sh_A,
        input  sh_B,
        input  sh_Shiftop,
        output sh_Result,
        input  out_valid,
        output out_ready,
        input  out_result,
        input  out_rd,
        input  out_illegal,
        input  op_count
    );
endinterface

// File: rtl/shift_exec_stage.sv
// Execute stage around the combinational barrel shifter:
// issue register drives the shifter, output register feeds MEM/WB.
module shift_exec_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
) (
    input  logic               clk,
    input  logic               rst,
    shift_exec_stage_if.slave  io
);

    localparam logic [5:0] F_SLL  = 6'b000000;
    localparam logic [5:0] F_SRL  = 6'b000010;
    localparam logic [5:0] F_SRA  = 6'b000011;
    localparam logic [5:0] F_SLLV = 6'b000100;
    localparam logic [5:0] F_SRLV = 6'b000110;
    localparam logic [5:0] F_SRAV = 6'b000111;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b10;
    localparam logic [1:0] OP_SRA = 2'b11;

    logic                  s1_valid_q, s1_valid_d;
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [4:0]            b_q, b_d;
    logic [1:0]            op_q, op_d;
    logic [4:0]            rd1_q, rd1_d;
    logic                  ill1_q, ill1_d;

    logic                  s2_valid_q, s2_valid_d;
    logic [DATA_WIDTH-1:0] res_q, res_d;
    logic [4:0]            rd2_q, rd2_d;
    logic                  ill2_q, ill2_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

    logic                  s2_free;
    logic                  s1_free;
    logic                  xfer;
    logic                  accept;
    logic                  retire;

    logic                  is_sll, is_srl, is_sra;
    logic                  is_sllv, is_srlv, is_srav;
    logic [4:0]            dec_b;
    logic [1:0]            dec_op;
    logic                  dec_ill;

    assign is_sll  = io.in_funct == F_SLL;
    assign is_srl  = io.in_funct == F_SRL;
    assign is_sra  = io.in_funct == F_SRA;
    assign is_sllv = io.in_funct == F_SLLV;
    assign is_srlv = io.in_funct == F_SRLV;
    assign is_srav = io.in_funct == F_SRAV;

    // Variable forms take only rs[4:0]; the upper rs bits are ignored.
    always_comb begin
        dec_b   = '0;
        dec_op  = OP_SLL;
        dec_ill = 1'b0;
        unique case (1'b1)
            is_sll: begin
                dec_b  = io.in_shamt;
                dec_op = OP_SLL;
            end
            is_srl: begin
                dec_b  = io.in_shamt;
                dec_op = OP_SRL;
            end
            is_sra: begin
                dec_b  = io.in_shamt;
                dec_op = OP_SRA;
            end
            is_sllv: begin
                dec_b  = io.in_rs_val[4:0];
                dec_op = OP_SLL;
            end
            is_srlv: begin
                dec_b  = io.in_rs_val[4:0];
                dec_op = OP_SRL;
            end
            is_srav: begin
                dec_b  = io.in_rs_val[4:0];
                dec_op = OP_SRA;
            end
            default: begin
                dec_ill = 1'b1;
            end
        endcase
    end

    // in_ready depends only on state and out_ready, never on in_valid.
    assign s2_free = ~s2_valid_q | io.out_ready;
    assign xfer    = s1_valid_q & s2_free;
    assign s1_free = ~s1_valid_q | xfer;
    assign accept  = io.in_valid & s1_free;
    assign retire  = s2_valid_q & io.out_ready;

    always_comb begin
        s1_valid_d = accept | (s1_valid_q & ~xfer);
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        rd1_d      = rd1_q;
        ill1_d     = ill1_q;
        if (accept) begin
            a_d    = io.in_rt_val;
            b_d    = dec_b;
            op_d   = dec_op;
            rd1_d  = io.in_rd;
            ill1_d = dec_ill;
        end
    end

    always_comb begin
        s2_valid_d = xfer | (s2_valid_q & ~io.out_ready);
        res_d      = res_q;
        rd2_d      = rd2_q;
        ill2_d     = ill2_q;
        if (xfer) begin
            res_d  = ill1_q ? '0 : io.sh_Result;
            rd2_d  = rd1_q;
            ill2_d = ill1_q;
        end
        cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, retire};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            rd1_q      <= '0;
            ill1_q     <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            rd1_q      <= rd1_d;
            ill1_q     <= ill1_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            res_q      <= '0;
            rd2_q      <= '0;
            ill2_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            s2_valid_q <= s2_valid_d;
            res_q      <= res_d;
            rd2_q      <= rd2_d;
            ill2_q     <= ill2_d;
            cnt_q      <= cnt_d;
        end
    end

    assign io.in_ready    = s1_free;
    assign io.sh_A        = a_q;
    assign io.sh_B        = b_q;
    assign io.sh_Shiftop  = op_q;
    assign io.out_valid   = s2_valid_q;
    assign io.out_result  = res_q;
    assign io.out_rd      = rd2_q;
    assign io.out_illegal = ill2_q;
    assign io.op_count    = cnt_q;

endmodule

// File: tb/tb_shift_exec_stage.sv
// Bench for shift_exec_stage: directed and random ops scored
// against an in-order queue model of the two-deep pipeline.
module tb_shift_exec_stage;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    shift_exec_stage_if #(.DATA_WIDTH(32), .CNT_WIDTH(32)) io();

    shift_exec_stage #(.DATA_WIDTH(32), .CNT_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .io  (io)
    );

    // Behavioural barrel shifter standing in for the real one.
    always_comb begin
        case (io.sh_Shiftop)
            2'b10:   io.sh_Result = io.sh_A >> io.sh_B;
            2'b11:   io.sh_Result = 32'($signed(io.sh_A) >>> io.sh_B);
            default: io.sh_Result = io.sh_A << io.sh_B;
        endcase
    end

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        ill;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    logic [31:0] cnt_m;
    logic [31:0] la;
    logic [4:0]  lb;
    logic [1:0]  lop;
    int          cur;
    int          errors = 0;
    int          checks = 0;
    logic [5:0]  legal [6] = '{6'd0, 6'd2, 6'd3, 6'd4, 6'd6, 6'd7};

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void ref_op(
        input  logic [5:0]  f,
        input  logic [4:0]  sh,
        input  logic [31:0] rs,
        input  logic [31:0] rt,
        output logic [31:0] res,
        output logic [4:0]  amt,
        output logic [1:0]  op,
        output logic        ill
    );
        res = 32'd0;
        amt = 5'd0;
        op  = 2'b00;
        ill = 1'b0;
        case (f)
            6'd0: begin amt = sh;      op = 2'b00; res = rt << amt; end
            6'd2: begin amt = sh;      op = 2'b10; res = rt >> amt; end
            6'd3: begin amt = sh;      op = 2'b11;
                        res = 32'($signed(rt) >>> amt); end
            6'd4: begin amt = rs[4:0]; op = 2'b00; res = rt << amt; end
            6'd6: begin amt = rs[4:0]; op = 2'b10; res = rt >> amt; end
            6'd7: begin amt = rs[4:0]; op = 2'b11;
                        res = 32'($signed(rt) >>> amt); end
            default: ill = 1'b1;
        endcase
    endfunction

    task automatic model_reset();
        q.delete();
        cnt_m = 32'd0;
        la    = 32'd0;
        lb    = 5'd0;
        lop   = 2'b00;
    endtask

    // One clock cycle: check at negedge, advance model, step past posedge.
    task automatic cyc();
        logic [31:0] r;
        logic [4:0]  a;
        logic [1:0]  o;
        logic        il;
        bit          vis;
        bit          rdy_m;
        @(negedge clk);
        rdy_m = (q.size() < 2) || io.out_ready;
        vis   = (q.size() > 0) && (q[0].cyc < cur - 1);
        chk("in_ready", io.in_ready, rdy_m);
        chk("out_valid", io.out_valid, vis);
        if (vis) begin
            chk("out_result", io.out_result, q[0].res);
            chk("out_rd", io.out_rd, q[0].rd);
            chk("out_illegal", io.out_illegal, q[0].ill);
        end
        chk("op_count", io.op_count, cnt_m);
        chk("sh_A", io.sh_A, la);
        chk("sh_B", io.sh_B, lb);
        chk("sh_Shiftop", io.sh_Shiftop, lop);
        if (vis && io.out_ready) begin
            void'(q.pop_front());
            cnt_m = cnt_m + 32'd1;
        end
        if (io.in_valid && rdy_m) begin
            ref_op(io.in_funct, io.in_shamt, io.in_rs_val,
                   io.in_rt_val, r, a, o, il);
            q.push_back('{res: r, rd: io.in_rd, ill: il, cyc: cur});
            la  = io.in_rt_val;
            lb  = a;
            lop = o;
        end
        @(posedge clk);
        #1;
        cur++;
    endtask

    task automatic drv(input bit v, input logic [5:0] f,
                       input logic [4:0] sh, input logic [31:0] rs,
                       input logic [31:0] rt, input logic [4:0] rd,
                       input bit ordy);
        io.in_valid  = v;
        io.in_funct  = f;
        io.in_shamt  = sh;
        io.in_rs_val = rs;
        io.in_rt_val = rt;
        io.in_rd     = rd;
        io.out_ready = ordy;
        cyc();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            drv(1'b0, 6'd0, 5'd0, 32'd0, 32'd0, 5'd0, 1'b1);
    endtask

    task automatic rnd(input int n, input int p_or);
        for (int i = 0; i < n; i++) begin
            logic [5:0] f;
            f = ($urandom % 8 == 0) ? 6'($urandom)
                                     : legal[$urandom % 6];
            drv(($urandom % 4) != 0, f, 5'($urandom), $urandom,
                $urandom, 5'($urandom), ($urandom % 100) < p_or);
        end
    endtask

    initial begin
        rst          = 1'b1;
        io.in_valid  = 1'b0;
        io.in_funct  = 6'd0;
        io.in_shamt  = 5'd0;
        io.in_rs_val = 32'd0;
        io.in_rt_val = 32'd0;
        io.in_rd     = 5'd0;
        io.out_ready = 1'b0;
        cur          = 0;
        model_reset();

        #3;
        chk("rst_out_valid", io.out_valid, 1'b0);
        chk("rst_op_count", io.op_count, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        idle(2);

        // sll 1<<4
        drv(1'b1, 6'd0, 5'd4, 32'd0, 32'h0000_0001, 5'd1, 1'b1);
        idle(3);
        chk("sll_op_count", io.op_count, 32'd1);

        // sra and srl of 0x80000000 by 4
        drv(1'b1, 6'd3, 5'd4, 32'd0, 32'h8000_0000, 5'd2, 1'b1);
        drv(1'b1, 6'd2, 5'd4, 32'd0, 32'h8000_0000, 5'd3, 1'b1);
        idle(3);

        // srlv uses only rs[4:0]
        drv(1'b1, 6'd6, 5'd0, 32'h0000_0023, 32'h0000_00F0, 5'd4, 1'b1);
        idle(3);

        // 8 back-to-back sllv at full throughput
        for (int i = 0; i < 8; i++)
            drv(1'b1, 6'd4, 5'd0, $urandom, $urandom, 5'(i), 1'b1);
        idle(3);

        // Stall output for 5 cycles while ID keeps offering
        for (int i = 0; i < 5; i++)
            drv(1'b1, 6'd4, 5'd0, $urandom, $urandom, 5'(20 + i), 1'b0);
        idle(4);

        // Illegal funct 0x20
        drv(1'b1, 6'h20, 5'd7, 32'd5, 32'hDEAD_BEEF, 5'd9, 1'b1);
        idle(3);

        rnd(300, 70);
        idle(4);

        // Fill both stages, then reset asynchronously between edges
        for (int i = 0; i < 3; i++)
            drv(1'b1, legal[$urandom % 6], 5'($urandom), $urandom,
                $urandom, 5'($urandom), 1'b0);
        chk("full_in_ready", io.in_ready, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", io.out_valid, 1'b0);
        chk("arst_op_count", io.op_count, 32'd0);
        chk("arst_sh_A", io.sh_A, 32'd0);
        @(posedge clk);
        #3 rst = 1'b0;
        model_reset();
        chk("post_rst_in_ready", io.in_ready, 1'b1);
        idle(4);

        rnd(80, 50);
        idle(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shift_exec_stage.md
Name: shift_exec_stage

Overview:
- Execute-stage wrapper that sits directly upstream and downstream of the combinational barrel shifter in the pipelined CPU.
- Accepts decoded MIPS shift instructions from ID with a valid/ready handshake and registers them into the issue stage.
- Derives the shifter's operand, amount and Shiftop, drives the shifter combinationally from the issue register, and captures its result into an output register for MEM/WB.
- Two-stage elastic pipeline with full backpressure, illegal-op flagging and a retired-op counter.

Parameters:
- DATA_WIDTH, 32, datapath width; fixed at 32, since the shifter amount is 5 bits.
- CNT_WIDTH, 32, width of the retired-operation counter.

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  ID offers an instruction
- in_ready  output  1  stage can accept this cycle
- in_funct  input  6  MIPS funct field
- in_shamt  input  5  immediate shift amount
- in_rs_val  input  32  rs value (variable amount in bits [4:0])
- in_rt_val  input  32  rt value (data to shift)
- in_rd  input  5  destination register
- sh_A  output  32  to shifter A
- sh_B  output  5  to shifter B
- sh_Shiftop  output  2  to shifter Shiftop (0x left, 10 logical right, 11 arithmetic right)
- sh_Result  input  32  from shifter Result
- out_valid  output  1  result available
- out_ready  input  1  downstream accepts
- out_result  output  32  registered shift result
- out_rd  output  5  registered destination
- out_illegal  output  1  funct was not a shift op
- op_count  output  CNT_WIDTH  number of results retired (out_valid & out_ready)

Behaviour:
- Reset (async, asserted): clear s1_valid, s2_valid, out_result, out_rd, out_illegal, op_count, sh_A, sh_B and sh_Shiftop to 0. out_valid=0; in_ready=1 on the first cycle after deassert.
- Decode of in_funct:
  - 000000 sll: B=shamt, op=00
  - 000010 srl: B=shamt, op=10
  - 000011 sra: B=shamt, op=11
  - 000100 sllv: B=rs[4:0], op=00
  - 000110 srlv: B=rs[4:0], op=10
  - 000111 srav: B=rs[4:0], op=11
  - any other value: illegal; B=0, op=00, illegal=1.
  - A=rt in every case.
- Stage 1 (issue register): holds A, B, op, rd, illegal and s1_valid. sh_A, sh_B and sh_Shiftop are driven directly from this register.
- Stage 2 (output register): on an s1->s2 transfer, captures out_result = illegal ? 0 : sh_Result, together with rd and illegal. out_valid = s2_valid.
- Advance rules:
  - s2_free = ~s2_valid | out_ready.
  - s1->s2 transfer when s1_valid & s2_free.
  - s1_free = ~s1_valid | (s1_valid & s2_free).
  - in_ready = s1_free, combinational from state and out_ready only; no in_valid->in_ready path.
  - Input accepted when in_valid & in_ready.
- Simultaneous events:
  - Accept, transfer and retire may all occur in one cycle. Full throughput is one op per cycle.
  - If s2 retires and s1 is empty, s2_valid goes 0 unless a transfer occurs that cycle.
- Latency: accept at edge N gives out_valid at edge N+1; the result is visible in cycle N+2 of the handshake, i.e. 2 registers deep.
- Backpressure:
  - With out_ready=0 and both stages full, in_ready=0.
  - All registered fields hold stable while out_valid & ~out_ready; no data is lost or duplicated.
- op_count increments by 1 on every out_valid & out_ready, including illegal ops, and wraps modulo 2^CNT_WIDTH.
- Reset mid-operation: in-flight ops are discarded, the counter is cleared, and no out_valid glitch occurs after deassert.
- Widths: B is truncated to 5 bits (rs[31:5] ignored). Shift by 0 passes A unchanged.

Test Plan:
- sll: rt=0x00000001, shamt=4, in_valid for 1 cycle, out_ready=1 -> out_valid 2 edges later, out_result=0x00000010, out_illegal=0, op_count=1.
- sra/srl: rt=0x80000000, shamt=4 -> sra gives 0xF8000000, srl gives 0x08000000; with sh_Shiftop observed as 11 and 10 respectively.
- srlv truncation: rs=0x00000023 (amount 3), rt=0x000000F0 -> out_result=0x0000001E, sh_B=3.
- Streaming and backpressure:
  - 8 back-to-back sllv ops with out_ready=1 -> one result per cycle, in order.
  - Then out_ready=0 for 5 cycles -> in_ready drops after 2 accepts; outputs stable; on release all ops retire in order, op_count=10.
- Illegal funct 0x20 -> out_result=0, out_illegal=1, op_count increments.
- rst pulsed asynchronously mid-stream with both stages full -> out_valid=0 and op_count=0 immediately; in_ready=1 after deassert; no stale result is emitted.
